mode_select_ctrl: RTL

- Front-panel controller that produces the 2-bit mode_select consumed by the output mode FSM.
- Turns two raw pushbuttons (next, off) into a registered mode:
  - short press of next cycles OFF -> PWM -> R2R -> BUZZER -> OFF;
  - long press of next, or any press of off, forces OFF.
- Also drives one-hot status LEDs and a mode-change pulse for logging/display.

---
 rtl/mode_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 46 ++++
 rtl/mode_select_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/mode_pkg.sv
// Shared encodings for the front-panel mode controller and the downstream output mode FSM.
package mode_pkg;

  typedef enum logic [1:0] {
    OFF_MODE    = 2'b00,
    PWM_MODE    = 2'b01,
    R2R_MODE    = 2'b10,
    BUZZER_MODE = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PRESSED   = 2'b01,
    LONG_HELD = 2'b10
  } press_state_t;

  function automatic logic [3:0] mode_onehot(input mode_t m);
    return 4'b0001 << m;
  endfunction

  function automatic mode_t mode_advance(input mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw pushbutton to clean level: 2-flop synchronizer, stability counter, edge pulses.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] CNT_LIM = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;
  logic            toggle;

  // Pulses are raised in the cycle whose edge flips db, so consumers act on the same edge.
  assign toggle = (sync2 != db) && (cnt == CNT_LIM);
  assign rise   = toggle & ~db;
  assign fall   = toggle & db;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (toggle) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/mode_select_ctrl.sv
// Front-panel mode selector: short next press advances the mode, long next press or off forces OFF.
//   state     | meaning
//   IDLE      | next released, waiting for a debounced press
//   PRESSED   | next held, timing for a long press
//   LONG_HELD | long press already forced OFF, waiting for release
module mode_select_ctrl
  import mode_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_off,
  output logic [1:0] mode_select,
  output logic [3:0] mode_led,
  output logic       mode_changed
);

  localparam int CNT_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic db_next, rise_next, fall_next;
  logic db_off, rise_off, fall_off;
  logic unused_off;

  press_state_t     state;
  logic [CNT_W-1:0] hold_cnt;
  mode_t            mode_q;
  mode_t            mode_prev;
  mode_t            mode_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_next),
    .db      (db_next),
    .rise    (rise_next),
    .fall    (fall_next)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_off (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_off),
    .db      (db_off),
    .rise    (rise_off),
    .fall    (fall_off)
  );

  assign unused_off = &{1'b0, db_off, fall_off};

  // Off press has the last word over any next-button action in the same cycle.
  always_comb begin
    mode_nxt = mode_q;
    if (state == PRESSED) begin
      if (fall_next)
        mode_nxt = mode_advance(mode_q);
      else if (hold_cnt == HOLD_LIM && db_next)
        mode_nxt = OFF_MODE;
    end
    if (rise_off)
      mode_nxt = OFF_MODE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      mode_q       <= OFF_MODE;
      mode_prev    <= OFF_MODE;
      mode_led     <= 4'b0001;
      mode_changed <= 1'b0;
    end else begin
      mode_q       <= mode_nxt;
      mode_led     <= mode_onehot(mode_nxt);
      mode_prev    <= mode_q;
      mode_changed <= (mode_q != mode_prev);
      case (state)
        IDLE: begin
          if (rise_next) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (fall_next)
            state <= IDLE;
          else if (hold_cnt == HOLD_LIM && db_next)
            state <= LONG_HELD;
          else if (hold_cnt != HOLD_LIM)
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
        LONG_HELD: begin
          if (fall_next)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mode_select = mode_q;

endmodule
